mem_port_sequencer: RTL and testbench
=====================================

# mem_port_sequencer

Multi-cycle sequencer that shares one single-ported memory between instruction fetch and data load/store for the RV32I core. Each instruction runs as fetch, decode, optional data access, then a one-cycle commit pulse. The core gates its PC update and register-file write with the commit pulse. A watchdog flags a hung memory.

## Interface
- TIMEOUT, 255: maximum cycles spent in any memory-wait state before error; 0 disables the watchdog
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  32  fetch address from core; held stable until `step`
- d_req  in  1  current instruction is load or store, decoded from `instr`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address (ALU result)
- d_wdata  in  32  store data
- instr  out  32  latched instruction
- d_rdata  out  32  latched load data
- step  out  1  one-cycle commit pulse
- bus_err  out  1  sticky watchdog error
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, at least 1 cycle after grant
- mem_rdata  in  32  read data

## Operation
- States: IDLE, F_REQ, F_WAIT, DECODE, D_REQ, D_WAIT, COMMIT, ERR.
- Reset values:
  - State: IDLE.
  - `instr`: 32'h00000013 (NOP).
  - `d_rdata`: 0.
  - `step`, `bus_err`, `mem_req`, `mem_we`: 0.
  - Watchdog count: 0.
- State transitions:
  - IDLE -> F_REQ unconditionally.
  - F_REQ: `mem_req`=1, `mem_addr`=`pc`, `mem_we`=0. On `mem_gnt` -> F_WAIT.
  - F_WAIT: on `mem_rvalid`, `instr`<=`mem_rdata` -> DECODE.
  - DECODE: one cycle so the core decodes the new `instr`. If `d_req` -> D_REQ, else -> COMMIT.
  - D_REQ: `mem_req`=1, `mem_addr`=`d_addr`, `mem_we`=`d_we`, `mem_wdata`=`d_wdata`.
    - On `mem_gnt` with `d_we`=1 (store) -> COMMIT.
    - On `mem_gnt` with `d_we`=0 (load) -> D_WAIT.
  - D_WAIT: on `mem_rvalid`, `d_rdata`<=`mem_rdata` -> COMMIT.
  - COMMIT: `step`=1 for exactly one cycle -> F_REQ.
  - ERR: `bus_err`=1, `mem_req`=0, `step`=0. Left only by reset.
- Output rules:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are combinational from state and inputs.
  - Outside D_REQ: `mem_addr`=`pc`, `mem_we`=0, `mem_wdata`=`d_wdata`.
- Handshake:
  - While `mem_req`=1 without `mem_gnt`, the address, write enable and write data stay stable, because core inputs are held.
  - `mem_rvalid` outside F_WAIT/D_WAIT is ignored.
  - `mem_gnt` outside F_REQ/D_REQ is ignored.
- `d_rdata` holds its value until the next load completes. `instr` holds its value until the next fetch completes.
- Watchdog:
  - The count clears on every state change.
  - It increments each cycle in F_REQ/F_WAIT/D_REQ/D_WAIT while the exit condition is false.
  - When the count reaches TIMEOUT with the exit condition still false -> ERR.
  - Exactly TIMEOUT wait cycles are tolerated: an exit condition arriving on wait cycle TIMEOUT+1 proceeds normally.
  - Count width is clog2(TIMEOUT+1), minimum 1. TIMEOUT=0: never enters ERR.
- Reset mid-operation: any state -> IDLE next edge. An outstanding memory response arriving afterwards is ignored, since IDLE/F_REQ ignore `mem_rvalid`.

## Timing
- First `mem_req` occurs in the 2nd cycle after `reset` deasserts.
- Zero-wait memory (`mem_gnt` same cycle, `mem_rvalid` next cycle), cycles per instruction:
  - ALU/branch/jump: 4.
  - Store: 5.
  - Load: 6.
- Each `mem_gnt` wait cycle adds 1 cycle. Each extra `mem_rvalid` delay cycle adds 1 cycle.
- `step` is high in exactly one cycle per instruction. The core latches next PC and performs the regfile write at the end of that cycle.
- `d_rdata` is valid from the COMMIT cycle of its load onward.

## Test plan
- Zero-wait memory:
  - Stimulus: `pc`=0x0, memory[0]=0x00500093 (addi).
  - Required: `mem_req` in cycles 2 and 6 after reset release; `step` high in cycle 5; `instr`=0x00500093 from cycle 4; `bus_err`=0.
- Load:
  - Stimulus: `d_req`=1, `d_we`=0, `d_addr`=0x100, memory[0x100]=0xDEADBEEF.
  - Required: second `mem_req` with `mem_addr`=0x100, `mem_we`=0; `d_rdata`=0xDEADBEEF at `step`; 6 cycles per instruction.
- Store:
  - Stimulus: `d_we`=1, `d_addr`=0x104, `d_wdata`=0x12345678; grant withheld 3 cycles.
  - Required: `mem_we`=1, with `mem_addr`/`mem_wdata` stable for all 4 request cycles; `step` the cycle after grant; no read-data wait.
- Watchdog, TIMEOUT=4:
  - Case A: `mem_gnt` never asserts. Required: ERR after 4 wait cycles, `bus_err`=1 sticky, `mem_req`=0, no `step`.
  - Case B: grant arrives on wait cycle 5. Required: no error.
- Reset mid-fetch:
  - Stimulus: reset in F_WAIT, then `mem_rvalid` with 0xFFFFFFFF the cycle after.
  - Required: `instr`=0x00000013 (data ignored); fetch restarts at `pc`.
- Spurious handshakes:
  - Stimulus: `mem_rvalid` pulsed during F_REQ and DECODE, `mem_gnt` pulsed during F_WAIT.
  - Required: no state change, `instr`/`d_rdata` unchanged.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: shares one single-ported memory between fetch and
// load/store, emits a one-cycle commit pulse, and flags a hung memory.
module mem_port_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] instr,
    output logic [31:0] d_rdata,
    output logic        step,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, F_REQ, F_WAIT, DECODE, D_REQ, D_WAIT, COMMIT, ERR
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   wd_cnt;
    logic            waiting;
    logic            exit_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state, memory port drive and status outputs.
    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = d_wdata;
        step      = 1'b0;
        bus_err   = 1'b0;
        waiting   = 1'b0;
        exit_c    = 1'b0;
        unique case (state)
            IDLE: state_n = F_REQ;
            F_REQ: begin
                mem_req = 1'b1;
                waiting = 1'b1;
                exit_c  = mem_gnt;
                if (mem_gnt) state_n = F_WAIT;
            end
            F_WAIT: begin
                waiting = 1'b1;
                exit_c  = mem_rvalid;
                if (mem_rvalid) state_n = DECODE;
            end
            DECODE: state_n = d_req ? D_REQ : COMMIT;
            D_REQ: begin
                mem_req  = 1'b1;
                mem_addr = d_addr;
                mem_we   = d_we;
                waiting  = 1'b1;
                exit_c   = mem_gnt;
                if (mem_gnt) state_n = d_we ? COMMIT : D_WAIT;
            end
            D_WAIT: begin
                waiting = 1'b1;
                exit_c  = mem_rvalid;
                if (mem_rvalid) state_n = COMMIT;
            end
            COMMIT: begin
                step    = 1'b1;
                state_n = F_REQ;
            end
            ERR: bus_err = 1'b1;
            default: state_n = IDLE;
        endcase
        // Watchdog: TIMEOUT wait cycles tolerated, the next stalled one errors.
        if (TIMEOUT != 0 && waiting && !exit_c && wd_cnt == TMAX)
            state_n = ERR;
    end

    // Watchdog counter: cleared on any state change, counts stalled waits.
    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt <= '0;
        else if (state_n != state)
            wd_cnt <= '0;
        else if (waiting && TIMEOUT != 0)
            wd_cnt <= wd_cnt + CW'(1);
    end

    // Instruction and load-data latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr   <= 32'h0000_0013;
            d_rdata <= 32'h0;
        end else begin
            if (state == F_WAIT && mem_rvalid) instr   <= mem_rdata;
            if (state == D_WAIT && mem_rvalid) d_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer: directed checks of fetch, load, store, watchdog,
// reset mid-fetch and spurious handshakes against hand-computed timelines.
module tb_mem_port_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] instr;
    logic [31:0] d_rdata;
    logic        step;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        auto_mem;
    logic        r_gnt, r_rvalid, m_gnt, m_rvalid;
    logic [31:0] r_rdata, m_rdata;
    logic        pend;
    logic [31:0] pend_data;
    int          wcnt;
    int          gnt_delay;
    int          st_delay;
    logic [31:0] mem [0:255];

    int n_tests;
    int n_fail;

    assign mem_gnt    = auto_mem ? r_gnt    : m_gnt;
    assign mem_rvalid = auto_mem ? r_rvalid : m_rvalid;
    assign mem_rdata  = auto_mem ? r_rdata  : m_rdata;

    mem_port_sequencer #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .instr      (instr),
        .d_rdata    (d_rdata),
        .step       (step),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: grant after a programmable stall, read data next cycle.
    always @(negedge clk) begin
        if (reset) begin
            r_gnt    = 1'b0;
            r_rvalid = 1'b0;
            r_rdata  = 32'h0;
            pend     = 1'b0;
            wcnt     = 0;
        end else begin
            r_rvalid = pend;
            r_rdata  = pend_data;
            pend     = 1'b0;
            if (mem_req && wcnt >= (mem_we ? st_delay : gnt_delay)) begin
                r_gnt = 1'b1;
                wcnt  = 0;
                if (!mem_we) begin
                    pend      = 1'b1;
                    pend_data = mem[mem_addr[9:2]];
                end
            end else begin
                r_gnt = 1'b0;
                if (mem_req) wcnt = wcnt + 1;
                else         wcnt = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench in cycle 1 after release (state IDLE).
    task automatic do_reset();
        reset    = 1'b1;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    logic [9:1]  zw_req, zw_step;
    logic [13:1] ld_req, ld_step;
    logic [10:1] wb_req, wb_step;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        auto_mem  = 1'b1;
        m_gnt     = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h0;
        pend_data = 32'h0;
        gnt_delay = 0;
        st_delay  = 0;
        pc        = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]    = 32'h0050_0093;
        mem[8'h40] = 32'hDEAD_BEEF;
        mem[8'h10] = 32'h0000_0113;

        // Zero-wait ALU instruction.
        zw_req  = 9'b000100010;
        zw_step = 9'b100010000;
        do_reset();
        chk("rst_instr", instr, 32'h13);
        chk("rst_drdata", d_rdata, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("zw_req%0d", c), {31'h0, mem_req}, {31'h0, zw_req[c]});
            chk($sformatf("zw_step%0d", c), {31'h0, step}, {31'h0, zw_step[c]});
            if (c == 2) chk("zw_addr", mem_addr, 32'h0);
            if (c == 3) chk("zw_instr_old", instr, 32'h13);
            if (c == 4) chk("zw_instr_new", instr, 32'h0050_0093);
            chk($sformatf("zw_err%0d", c), {31'h0, bus_err}, 32'h0);
            tick();
        end

        // Loads: six cycles per instruction.
        ld_req  = 13'b0010010010010;
        ld_step = 13'b1000001000000;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h100;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("ld_req%0d", c), {31'h0, mem_req}, {31'h0, ld_req[c]});
            chk($sformatf("ld_step%0d", c), {31'h0, step}, {31'h0, ld_step[c]});
            if (c == 5) begin
                chk("ld_addr", mem_addr, 32'h100);
                chk("ld_we", {31'h0, mem_we}, 32'h0);
            end
            if (c == 6) chk("ld_drdata_pre", d_rdata, 32'h0);
            if (c == 7) chk("ld_drdata", d_rdata, 32'hDEAD_BEEF);
            tick();
        end

        // Store with grant withheld three cycles.
        d_we     = 1'b1;
        d_addr   = 32'h104;
        d_wdata  = 32'h1234_5678;
        st_delay = 3;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c >= 5 && c <= 8) begin
                chk($sformatf("st_req%0d", c), {31'h0, mem_req}, 32'h1);
                chk($sformatf("st_we%0d", c), {31'h0, mem_we}, 32'h1);
                chk($sformatf("st_addr%0d", c), mem_addr, 32'h104);
                chk($sformatf("st_wdata%0d", c), mem_wdata, 32'h1234_5678);
                chk($sformatf("st_nostep%0d", c), {31'h0, step}, 32'h0);
            end
            if (c == 9) begin
                chk("st_step", {31'h0, step}, 32'h1);
                chk("st_req_commit", {31'h0, mem_req}, 32'h0);
            end
            if (c == 10) begin
                chk("st_refetch_req", {31'h0, mem_req}, 32'h1);
                chk("st_refetch_we", {31'h0, mem_we}, 32'h0);
                chk("st_refetch_addr", mem_addr, 32'h0);
                chk("st_drdata", d_rdata, 32'h0);
            end
            tick();
        end
        st_delay = 0;

        // Watchdog case A: grant never arrives.
        d_req     = 1'b0;
        d_we      = 1'b0;
        gnt_delay = 1000;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("wa_step%0d", c), {31'h0, step}, 32'h0);
            if (c >= 2 && c <= 6) begin
                chk($sformatf("wa_req%0d", c), {31'h0, mem_req}, 32'h1);
                chk($sformatf("wa_err%0d", c), {31'h0, bus_err}, 32'h0);
            end
            if (c >= 7) begin
                chk($sformatf("wa_req%0d", c), {31'h0, mem_req}, 32'h0);
                chk($sformatf("wa_err%0d", c), {31'h0, bus_err}, 32'h1);
            end
            tick();
        end

        // Watchdog case B: grant on the fifth cycle of the request.
        wb_req    = 10'b1000100010 & 10'b1000111110;
        wb_req    = 10'b1000111110;
        wb_step   = 10'b0100000000;
        gnt_delay = 4;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("wb_req%0d", c), {31'h0, mem_req}, {31'h0, wb_req[c]});
            chk($sformatf("wb_step%0d", c), {31'h0, step}, {31'h0, wb_step[c]});
            chk($sformatf("wb_err%0d", c), {31'h0, bus_err}, 32'h0);
            tick();
        end
        gnt_delay = 0;

        // Reset in F_WAIT with a late response arriving in IDLE.
        auto_mem = 1'b0;
        pc       = 32'h40;
        do_reset();
        tick();
        chk("rm_req", {31'h0, mem_req}, 32'h1);
        chk("rm_addr", mem_addr, 32'h40);
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        chk("rm_fwait", {31'h0, mem_req}, 32'h0);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hFFFF_FFFF;
        chk("rm_idle_instr", instr, 32'h13);
        chk("rm_idle_req", {31'h0, mem_req}, 32'h0);
        tick();
        m_rvalid = 1'b0;
        chk("rm_instr", instr, 32'h13);
        chk("rm_restart_req", {31'h0, mem_req}, 32'h1);
        chk("rm_restart_addr", mem_addr, 32'h40);
        tick();
        chk("rm_hold_req", {31'h0, mem_req}, 32'h1);
        m_gnt = 1'b1;
        tick();
        m_gnt    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h0050_0093;
        tick();
        m_rvalid = 1'b0;
        chk("rm_fetch_ok", instr, 32'h0050_0093);

        // Spurious handshakes in states that must ignore them.
        pc = 32'h0;
        do_reset();
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 32'hAAAA_AAAA;
        tick();
        m_rvalid = 1'b0;
        chk("sp_freq_hold", {31'h0, mem_req}, 32'h1);
        chk("sp_freq_instr", instr, 32'h13);
        m_gnt = 1'b1;
        tick();
        chk("sp_fwait", {31'h0, mem_req}, 32'h0);
        tick();
        m_gnt = 1'b0;
        chk("sp_fwait_hold", {31'h0, mem_req}, 32'h0);
        chk("sp_fwait_instr", instr, 32'h13);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0050_0093;
        tick();
        chk("sp_decode_instr", instr, 32'h0050_0093);
        chk("sp_decode_step", {31'h0, step}, 32'h0);
        m_rdata = 32'hFFFF_FFFF;
        tick();
        m_rvalid = 1'b0;
        chk("sp_commit_step", {31'h0, step}, 32'h1);
        chk("sp_commit_instr", instr, 32'h0050_0093);
        chk("sp_commit_drdata", d_rdata, 32'h0);
        tick();
        chk("sp_refetch_req", {31'h0, mem_req}, 32'h1);
        chk("sp_refetch_instr", instr, 32'h0050_0093);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
